trap_ctrl: RTL and testbench
============================

// Module: trap_ctrl
// PURPOSE
//  Trap/return sequencer owning the single CSR write port (mtvec/mepc/mcause/mstatus file).
//  On ECALL/exception/interrupt it serialises mepc, mcause and mstatus updates, then redirects fetch to mtvec.
//  On MRET it restores mstatus, then redirects to mepc.
//  Sits between the pipeline's CSR-write path and the CSR register file; stalls the pipeline while busy.
// PARAMETERS
//  data_width      32   CSR data width
//  csr_addr_width  12   CSR address width
// PORTS
//  clk              in   1    clock
//  rst              in   1    reset, asynchronous, active-low
//  trap_valid       in   1    trap or MRET request from pipeline (held until accepted)
//  trap_is_mret     in   1    1 = MRET, 0 = trap entry
//  trap_cause       in   32   mcause value; bit31 = interrupt
//  trap_pc          in   32   PC of trapping instruction
//  trap_ready       out  1    request accepted when trap_valid && trap_ready
//  pipe_csr_we      in   1    pipeline CSR-instruction write enable
//  pipe_csr_addr    in   12   pipeline CSR write address
//  pipe_csr_wdata   in   32   pipeline CSR write data
//  csr_mtvec        in   32   current mtvec
//  csr_mepc         in   32   current mepc
//  csr_mstatus      in   32   current mstatus
//  csr_we           out  1    to CSR file write enable
//  csr_addr_w       out  12   to CSR file write address
//  csr_wdata        out  32   to CSR file write data
//  stall            out  1    pipeline hold
//  redirect_valid   out  1    one-cycle fetch redirect strobe
//  redirect_pc      out  32   redirect target
// BEHAVIOUR
//  States: IDLE, E_EPC, E_CAUSE, E_STATUS, R_STATUS, REDIRECT.
//  Reset: state IDLE; csr_we=0, csr_addr_w=0, csr_wdata=0, stall=0, redirect_valid=0, redirect_pc=0, trap_ready=1.
//  trap_ready = (state==IDLE); stall = (state!=IDLE).
//  IDLE: CSR port passes pipe_csr_* through. On accept: latch pc, cause, kind and mstatus snapshot.
//   Accept cycle with pipe write to 0x300: pass-through write happens; snapshot takes pipe_csr_wdata, not csr_mstatus.
//   Trap entry -> E_EPC; MRET -> R_STATUS.
//  E_EPC: write 0x341 = {pc[31:2],2'b00}. -> E_CAUSE.
//  E_CAUSE: write 0x342 = cause. -> E_STATUS.
//  E_STATUS: write 0x300 = snap with MPIE[7]=MIE[3], MIE[3]=0, MPP[12:11]=2'b11. -> REDIRECT.
//  R_STATUS: write 0x300 = snap with MIE[3]=MPIE[7], MPIE[7]=1, MPP=2'b11. -> REDIRECT.
//  REDIRECT: csr_we=0, redirect_valid=1 (registered pulse, exactly one cycle). -> IDLE.
//   Entry: mtvec[1:0]==2'b01 and cause[31]=1 -> {mtvec[31:2],2'b00} + 4*cause[4:0]; else {mtvec[31:2],2'b00}.
//   MRET: {csr_mepc[31:2],2'b00}, sampled in REDIRECT (sees completed writes).
//  Latency: accept at cycle N; entry redirect at N+4, MRET redirect at N+2; trap_ready high again at N+5 / N+3.
//  Busy states: pipe_csr_we ignored (pipeline is stalled); asserting it is a protocol error flagged by assertion.
//  trap_valid while busy: not accepted; held request accepted on first IDLE cycle.
//  Reset mid-sequence: immediate return to reset values; partial CSR writes are discarded by CSR-file reset.
//  All arithmetic 32-bit, wrap-around on vector add ignored (mtvec base aligned by software).
// STRUCTURE
//  csr_pkg: CSR addresses (MSTATUS 12'h300, MTVEC 12'h305, MEPC 12'h341, MCAUSE 12'h342),
//   mstatus bit positions (MIE 3, MPIE 7, MPP 12:11), mtvec mode codes, FSM state encoding.
//  Sub-module trap_vec_calc (combinational): mtvec, cause, mode -> entry target PC.
//  Remaining FSM, snapshot registers and write-port mux in trap_ctrl.
// TESTING
//  ECALL pc=0x100 cause=11 mstatus=0x1808 mtvec=0x170 -> writes 0x341=0x100, 0x342=0xB, 0x300=0x1880; redirect 0x170 at N+4.
//  MRET mepc=0x104 mstatus=0x1880 -> single write 0x300=0x1888; redirect 0x104 at N+2; stall high N+1..N+2.
//  Vectored mtvec=0x201: cause=0x80000007 -> redirect 0x21C; cause=2 -> redirect 0x200.
//  Accept cycle with pipe write 0x300=0x1808 (prior mstatus 0x1800) -> passthrough then E_STATUS writes 0x1880.
//  Second trap_valid held during busy -> trap_ready=0, no extra writes; accepted at N+5, redirect at N+9.
//  rst low in E_CAUSE -> all outputs reset values, no redirect pulse; after release trap_ready=1, clean ECALL works.

Source files
------------

// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the trap/return sequencer: CSR addresses, mstatus
// field positions, mtvec mode codes, FSM encoding and mstatus update helpers.
package trap_ctrl_pkg;

    localparam logic [11:0] CsrMstatus = 12'h300;
    localparam logic [11:0] CsrMtvec   = 12'h305;
    localparam logic [11:0] CsrMepc    = 12'h341;
    localparam logic [11:0] CsrMcause  = 12'h342;

    localparam int unsigned MstatusMie   = 3;
    localparam int unsigned MstatusMpie  = 7;
    localparam int unsigned MstatusMppLo = 11;
    localparam int unsigned MstatusMppHi = 12;

    localparam logic [1:0] MtvecDirect   = 2'b00;
    localparam logic [1:0] MtvecVectored = 2'b01;

    typedef enum logic [2:0] {
        StIdle,
        StEEpc,
        StECause,
        StEStatus,
        StRStatus,
        StRedirect
    } trap_state_e;

    // Trap entry: stash MIE in MPIE, mask interrupts, record M-mode as previous mode.
    function automatic logic [31:0] mstatus_on_entry(input logic [31:0] s);
        logic [31:0] r;
        r = s;
        r[MstatusMpie] = s[MstatusMie];
        r[MstatusMie]  = 1'b0;
        r[MstatusMppHi:MstatusMppLo] = 2'b11;
        return r;
    endfunction

    // Trap return: restore MIE from MPIE, re-arm MPIE, previous mode stays M.
    function automatic logic [31:0] mstatus_on_mret(input logic [31:0] s);
        logic [31:0] r;
        r = s;
        r[MstatusMie]  = s[MstatusMpie];
        r[MstatusMpie] = 1'b1;
        r[MstatusMppHi:MstatusMppLo] = 2'b11;
        return r;
    endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// Bundle of the pipeline request, pipeline CSR-write, CSR-file and fetch
// redirect signals around trap_ctrl. master = pipeline/CSR-file side.
interface trap_ctrl_if #(
    parameter int unsigned data_width     = 32,
    parameter int unsigned csr_addr_width = 12
);
    logic                      trap_valid;
    logic                      trap_is_mret;
    logic [data_width-1:0]     trap_cause;
    logic [data_width-1:0]     trap_pc;
    logic                      trap_ready;

    logic                      pipe_csr_we;
    logic [csr_addr_width-1:0] pipe_csr_addr;
    logic [data_width-1:0]     pipe_csr_wdata;

    logic [data_width-1:0]     csr_mtvec;
    logic [data_width-1:0]     csr_mepc;
    logic [data_width-1:0]     csr_mstatus;

    logic                      csr_we;
    logic [csr_addr_width-1:0] csr_addr_w;
    logic [data_width-1:0]     csr_wdata;

    logic                      stall;
    logic                      redirect_valid;
    logic [data_width-1:0]     redirect_pc;

    modport master (
        output trap_valid, trap_is_mret, trap_cause, trap_pc,
        output pipe_csr_we, pipe_csr_addr, pipe_csr_wdata,
        output csr_mtvec, csr_mepc, csr_mstatus,
        input  trap_ready, csr_we, csr_addr_w, csr_wdata,
        input  stall, redirect_valid, redirect_pc
    );

    modport slave (
        input  trap_valid, trap_is_mret, trap_cause, trap_pc,
        input  pipe_csr_we, pipe_csr_addr, pipe_csr_wdata,
        input  csr_mtvec, csr_mepc, csr_mstatus,
        output trap_ready, csr_we, csr_addr_w, csr_wdata,
        output stall, redirect_valid, redirect_pc
    );

endinterface

// File: rtl/trap_vec_calc.sv
// Trap entry target: mtvec base, offset by 4*cause for interrupts in vectored mode.
module trap_vec_calc
    import trap_ctrl_pkg::*;
(
    input  logic [31:0] mtvec_i,
    input  logic [31:0] cause_i,
    output logic [31:0] target_o
);

    logic [31:0] base;
    logic        unused_cause;

    assign base         = {mtvec_i[31:2], 2'b00};
    assign unused_cause = ^cause_i[30:5];

    // Reserved mode encodings fall back to direct mode.
    always_comb begin
        target_o = base;
        case (mtvec_i[1:0])
            MtvecDirect:   target_o = base;
            MtvecVectored: begin
                if (cause_i[31]) begin
                    target_o = base + {25'b0, cause_i[4:0], 2'b00};
                end
            end
            default:       target_o = base;
        endcase
    end

endmodule

// File: rtl/trap_ctrl.sv
// Trap/return sequencer. Owns the single CSR write port: passes pipeline CSR
// writes through while idle, otherwise serialises mepc/mcause/mstatus updates
// for a trap (or the mstatus restore for MRET) and then pulses a fetch redirect.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int unsigned data_width     = 32,
    parameter int unsigned csr_addr_width = 12
) (
    input  logic       clk,
    input  logic       rst,
    trap_ctrl_if.slave bus
);

    trap_state_e               state_q, state_d;
    logic [data_width-1:0]     cause_q, cause_d;
    logic [data_width-1:0]     snap_q, snap_d;
    logic                      mret_q, mret_d;
    logic                      fsm_we_q, fsm_we_d;
    logic [csr_addr_width-1:0] fsm_addr_q, fsm_addr_d;
    logic [data_width-1:0]     fsm_wdata_q, fsm_wdata_d;
    logic                      redirect_valid_q, redirect_valid_d;

    logic                      idle;
    logic                      accept;
    logic                      pipe_wr_mstatus;
    logic [data_width-1:0]     vec_pc;
    logic                      unused_bits;

    assign idle            = (state_q == StIdle);
    assign accept          = idle & bus.trap_valid;
    assign pipe_wr_mstatus = bus.pipe_csr_we & (bus.pipe_csr_addr == CsrMstatus);
    assign unused_bits     = ^{bus.trap_pc[1:0], bus.csr_mepc[1:0]};

    trap_vec_calc u_vec_calc (
        .mtvec_i  (bus.csr_mtvec),
        .cause_i  (cause_q),
        .target_o (vec_pc)
    );

    // Next state; fsm_* describe the CSR write to issue in the state being entered.
    always_comb begin
        state_d          = state_q;
        cause_d          = cause_q;
        snap_d           = snap_q;
        mret_d           = mret_q;
        fsm_we_d         = 1'b0;
        fsm_addr_d       = '0;
        fsm_wdata_d      = '0;
        redirect_valid_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    cause_d  = bus.trap_cause;
                    mret_d   = bus.trap_is_mret;
                    // A same-cycle pipeline write to mstatus lands first, so it is the base.
                    snap_d   = pipe_wr_mstatus ? bus.pipe_csr_wdata : bus.csr_mstatus;
                    fsm_we_d = 1'b1;
                    if (bus.trap_is_mret) begin
                        state_d     = StRStatus;
                        fsm_addr_d  = CsrMstatus;
                        fsm_wdata_d = mstatus_on_mret(snap_d);
                    end else begin
                        state_d     = StEEpc;
                        fsm_addr_d  = CsrMepc;
                        fsm_wdata_d = {bus.trap_pc[31:2], 2'b00};
                    end
                end
            end
            StEEpc: begin
                state_d     = StECause;
                fsm_we_d    = 1'b1;
                fsm_addr_d  = CsrMcause;
                fsm_wdata_d = cause_q;
            end
            StECause: begin
                state_d     = StEStatus;
                fsm_we_d    = 1'b1;
                fsm_addr_d  = CsrMstatus;
                fsm_wdata_d = mstatus_on_entry(snap_q);
            end
            StEStatus, StRStatus: begin
                state_d          = StRedirect;
                redirect_valid_d = 1'b1;
            end
            StRedirect: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, snapshot and registered write-port/redirect strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= StIdle;
            cause_q          <= '0;
            snap_q           <= '0;
            mret_q           <= 1'b0;
            fsm_we_q         <= 1'b0;
            fsm_addr_q       <= '0;
            fsm_wdata_q      <= '0;
            redirect_valid_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            cause_q          <= cause_d;
            snap_q           <= snap_d;
            mret_q           <= mret_d;
            fsm_we_q         <= fsm_we_d;
            fsm_addr_q       <= fsm_addr_d;
            fsm_wdata_q      <= fsm_wdata_d;
            redirect_valid_q <= redirect_valid_d;
        end
    end

    // CSR port mux: pipeline owns it only while idle; address/data held at 0 when quiet.
    always_comb begin
        if (idle) begin
            bus.csr_we     = bus.pipe_csr_we;
            bus.csr_addr_w = bus.pipe_csr_we ? bus.pipe_csr_addr : '0;
            bus.csr_wdata  = bus.pipe_csr_we ? bus.pipe_csr_wdata : '0;
        end else begin
            bus.csr_we     = fsm_we_q;
            bus.csr_addr_w = fsm_addr_q;
            bus.csr_wdata  = fsm_wdata_q;
        end
    end

    // Target is read live in REDIRECT so an MRET sees every write already committed.
    always_comb begin
        bus.redirect_pc = '0;
        if (state_q == StRedirect) begin
            bus.redirect_pc = mret_q ? {bus.csr_mepc[31:2], 2'b00} : vec_pc;
        end
    end

    assign bus.trap_ready     = idle;
    assign bus.stall          = ~idle;
    assign bus.redirect_valid = redirect_valid_q;

    // The pipeline is held while busy, so a CSR write from it would be silently dropped.
    pipe_write_while_busy_a: assert property (
        @(posedge clk) disable iff (!rst) !idle |-> !bus.pipe_csr_we
    );

    // mtvec is read in REDIRECT; the sequencer itself must never disturb it.
    no_fsm_mtvec_write_a: assert property (
        @(posedge clk) disable iff (!rst) !idle |-> !(fsm_we_q && fsm_addr_q == CsrMtvec)
    );

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: table of trap/MRET vectors plus hand sequences for the
// accept-cycle mstatus write, a request held while busy, and reset mid-sequence.
module tb_trap_ctrl;

    typedef struct {
        logic        mret;
        logic [31:0] cause;
        logic [31:0] pc;
        logic [31:0] mstatus;
        logic [31:0] mtvec;
        logic [31:0] mepc;
        logic [31:0] w_epc;
        logic [31:0] w_status;
        logic [31:0] rpc;
    } vec_t;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
        int          cyc;
    } exp_wr_t;

    typedef struct {
        logic [31:0] pc;
        int          cyc;
    } exp_rd_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    exp_wr_t wq[$];
    exp_rd_t rq[$];
    exp_wr_t mon_w;
    exp_rd_t mon_r;
    vec_t    vecs[8];

    // Small CSR file fed only by the DUT write port.
    logic [31:0] m_mtvec   = 32'h0;
    logic [31:0] m_mepc    = 32'h0;
    logic [31:0] m_mstatus = 32'h0;
    logic [31:0] m_mcause  = 32'h0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    trap_ctrl_if bus ();

    trap_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.csr_mtvec   = m_mtvec;
    assign bus.csr_mepc    = m_mepc;
    assign bus.csr_mstatus = m_mstatus;

    always @(posedge clk) begin
        if (bus.csr_we) begin
            case (bus.csr_addr_w)
                12'h300: m_mstatus <= bus.csr_wdata;
                12'h305: m_mtvec   <= bus.csr_wdata;
                12'h341: m_mepc    <= bus.csr_wdata;
                12'h342: m_mcause  <= bus.csr_wdata;
                default: ;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_w(input logic [11:0] a, input logic [31:0] d, input int c);
        exp_wr_t e;
        e.addr = a;
        e.data = d;
        e.cyc  = c;
        wq.push_back(e);
    endtask

    task automatic push_r(input logic [31:0] p, input int c);
        exp_rd_t e;
        e.pc  = p;
        e.cyc = c;
        rq.push_back(e);
    endtask

    // Scoreboard: every write/redirect strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (bus.csr_we === 1'b1) begin
            if (wq.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write @cyc %0d: got addr %h data %h, expected none",
                         cyc, bus.csr_addr_w, bus.csr_wdata);
            end else begin
                mon_w = wq.pop_front();
                check("write_addr", {20'b0, bus.csr_addr_w}, {20'b0, mon_w.addr});
                check("write_data", bus.csr_wdata, mon_w.data);
                check("write_cycle", cyc, mon_w.cyc);
            end
        end
        if (bus.redirect_valid === 1'b1) begin
            if (rq.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_redirect @cyc %0d: got pc %h, expected none",
                         cyc, bus.redirect_pc);
            end else begin
                mon_r = rq.pop_front();
                check("redirect_pc", bus.redirect_pc, mon_r.pc);
                check("redirect_cycle", cyc, mon_r.cyc);
            end
        end
    end

    task automatic pipe_wr(input logic [11:0] a, input logic [31:0] d);
        bus.pipe_csr_we    = 1'b1;
        bus.pipe_csr_addr  = a;
        bus.pipe_csr_wdata = d;
        push_w(a, d, cyc);
        tick();
        bus.pipe_csr_we    = 1'b0;
        bus.pipe_csr_addr  = '0;
        bus.pipe_csr_wdata = '0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_csr_we"}, {31'b0, bus.csr_we}, 32'h0);
        check({tag, "_csr_addr_w"}, {20'b0, bus.csr_addr_w}, 32'h0);
        check({tag, "_csr_wdata"}, bus.csr_wdata, 32'h0);
        check({tag, "_stall"}, {31'b0, bus.stall}, 32'h0);
        check({tag, "_redirect_valid"}, {31'b0, bus.redirect_valid}, 32'h0);
        check({tag, "_redirect_pc"}, bus.redirect_pc, 32'h0);
        check({tag, "_trap_ready"}, {31'b0, bus.trap_ready}, 32'h1);
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_writes_pending"}, wq.size(), 32'h0);
        check({tag, "_redirects_pending"}, rq.size(), 32'h0);
    endtask

    task automatic set_trap(input logic mret, input logic [31:0] cause, input logic [31:0] pc);
        bus.trap_valid   = 1'b1;
        bus.trap_is_mret = mret;
        bus.trap_cause   = cause;
        bus.trap_pc      = pc;
    endtask

    task automatic clear_trap();
        bus.trap_valid   = 1'b0;
        bus.trap_is_mret = 1'b0;
        bus.trap_cause   = '0;
        bus.trap_pc      = '0;
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        int lat;
        pipe_wr(12'h305, v.mtvec);
        pipe_wr(12'h341, v.mepc);
        pipe_wr(12'h300, v.mstatus);
        set_trap(v.mret, v.cause, v.pc);
        n = cyc;
        if (v.mret) begin
            lat = 2;
            push_w(12'h300, v.w_status, n + 1);
        end else begin
            lat = 4;
            push_w(12'h341, v.w_epc, n + 1);
            push_w(12'h342, v.cause, n + 2);
            push_w(12'h300, v.w_status, n + 3);
        end
        push_r(v.rpc, n + lat);
        @(negedge clk);
        check("accept_ready", {31'b0, bus.trap_ready}, 32'h1);
        tick();
        clear_trap();
        for (int i = 1; i <= lat + 1; i++) begin
            @(negedge clk);
            check("busy_stall", {31'b0, bus.stall}, (i <= lat) ? 32'h1 : 32'h0);
            check("busy_ready", {31'b0, bus.trap_ready}, (i > lat) ? 32'h1 : 32'h0);
        end
        tick();
        check_drained("vec");
    endtask

    initial begin
        int n;
        clear_trap();
        bus.pipe_csr_we    = 1'b0;
        bus.pipe_csr_addr  = '0;
        bus.pipe_csr_wdata = '0;

        //         mret  cause         pc            mstatus       mtvec         mepc
        //               w_epc         w_status      redirect
        vecs[0] = '{1'b0, 32'h0000000B, 32'h00000100, 32'h00001808, 32'h00000170, 32'h0,
                    32'h00000100, 32'h00001880, 32'h00000170};
        vecs[1] = '{1'b1, 32'h0, 32'h0, 32'h00001880, 32'h00000170, 32'h00000104,
                    32'h0, 32'h00001888, 32'h00000104};
        vecs[2] = '{1'b0, 32'h80000007, 32'h00000200, 32'h00000000, 32'h00000201, 32'h0,
                    32'h00000200, 32'h00001800, 32'h0000021C};
        vecs[3] = '{1'b0, 32'h00000002, 32'h20000106, 32'h00000008, 32'h00000201, 32'h0,
                    32'h20000104, 32'h00001880, 32'h00000200};
        vecs[4] = '{1'b1, 32'h0, 32'h0, 32'h00000000, 32'h00000201, 32'h80000003,
                    32'h0, 32'h00001880, 32'h80000000};
        vecs[5] = '{1'b0, 32'h8000001F, 32'h00000004, 32'hFFFFFFFF, 32'h00000101, 32'h0,
                    32'h00000004, 32'hFFFFFFF7, 32'h0000017C};
        vecs[6] = '{1'b0, 32'h80000003, 32'h00000008, 32'h00000080, 32'h00000302, 32'h0,
                    32'h00000008, 32'h00001800, 32'h00000300};
        vecs[7] = '{1'b1, 32'h0, 32'h0, 32'h00000088, 32'h00000302, 32'h00000010,
                    32'h0, 32'h00001888, 32'h00000010};

        // Reset values while held in reset.
        tick();
        tick();
        @(negedge clk);
        check_idle_outputs("reset");
        tick();
        rst = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i]);
        end

        // Accept cycle carries a pipeline mstatus write: it passes through and seeds the snapshot.
        pipe_wr(12'h300, 32'h00001800);
        pipe_wr(12'h305, 32'h00000170);
        bus.pipe_csr_we    = 1'b1;
        bus.pipe_csr_addr  = 12'h300;
        bus.pipe_csr_wdata = 32'h00001808;
        set_trap(1'b0, 32'h0000000B, 32'h00000100);
        n = cyc;
        push_w(12'h300, 32'h00001808, n);
        push_w(12'h341, 32'h00000100, n + 1);
        push_w(12'h342, 32'h0000000B, n + 2);
        push_w(12'h300, 32'h00001880, n + 3);
        push_r(32'h00000170, n + 4);
        tick();
        bus.pipe_csr_we    = 1'b0;
        bus.pipe_csr_addr  = '0;
        bus.pipe_csr_wdata = '0;
        clear_trap();
        repeat (5) tick();
        check_drained("accept_wr");

        // Second request held through the busy window, taken on the first idle cycle.
        pipe_wr(12'h300, 32'h00001808);
        set_trap(1'b0, 32'h0000000B, 32'h00000100);
        n = cyc;
        push_w(12'h341, 32'h00000100, n + 1);
        push_w(12'h342, 32'h0000000B, n + 2);
        push_w(12'h300, 32'h00001880, n + 3);
        push_r(32'h00000170, n + 4);
        push_w(12'h341, 32'h00000200, n + 6);
        push_w(12'h342, 32'h00000008, n + 7);
        push_w(12'h300, 32'h00001800, n + 8);
        push_r(32'h00000170, n + 9);
        @(negedge clk);
        check("held_first_ready", {31'b0, bus.trap_ready}, 32'h1);
        tick();
        set_trap(1'b0, 32'h00000008, 32'h00000200);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            check("held_ready", {31'b0, bus.trap_ready}, (i == 5) ? 32'h1 : 32'h0);
        end
        tick();
        clear_trap();
        repeat (5) tick();
        check_drained("held");

        // Reset asserted while in E_CAUSE: everything back to reset values, no redirect.
        pipe_wr(12'h300, 32'h00001808);
        set_trap(1'b0, 32'h0000000B, 32'h00000100);
        n = cyc;
        push_w(12'h341, 32'h00000100, n + 1);
        tick();
        clear_trap();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("mid_reset");
        tick();
        tick();
        rst = 1'b1;
        tick();
        tick();
        check_drained("mid_reset");
        @(negedge clk);
        check("post_reset_ready", {31'b0, bus.trap_ready}, 32'h1);
        tick();
        run_vec(vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
